// File: rtl/rf_arb_pkg.sv
// Shared widths and the writeback request payload used by the register-file
// write-port arbiter and its long-latency result FIFO.
package rf_arb_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned NREG      = 32;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small circular buffer for long-latency writeback results; DEPTH must be a
// power of two so the pointers wrap naturally.
module rf_wb_fifo
    import rf_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  wb_req_t push_req,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    wb_req_t          mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_req;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline WB has priority, buffered
// long-latency results drain into idle slots; a pending scoreboard raises the
// decode hazard. Define RF_ARB_STARVE_GUARD_EN to enable the starvation guard.
module rf_wb_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pipe_wb_en,
    input  logic [REG_IDX_W-1:0] pipe_rd,
    input  logic [XLEN-1:0]      pipe_wb_data,
    input  logic                 lu_valid,
    output logic                 lu_ready,
    input  logic [REG_IDX_W-1:0] lu_rd,
    input  logic [XLEN-1:0]      lu_data,
    input  logic                 issue_en,
    input  logic [REG_IDX_W-1:0] issue_rd,
    input  logic [REG_IDX_W-1:0] chk_rs1,
    input  logic [REG_IDX_W-1:0] chk_rs2,
    input  logic [REG_IDX_W-1:0] chk_rd,
    output logic                 hazard,
    output logic                 busy,
    output logic                 pipe_stall,
    output logic                 rf_wb_en,
    output logic [REG_IDX_W-1:0] rf_rd,
    output logic [XLEN-1:0]      rf_wb_data
);

    logic            pipe_valid;
    logic            pipe_grant;
    logic            pop;
    logic            push;
    logic            full;
    logic            empty;
    wb_req_t         head;
    wb_req_t         push_req;
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_next;

    assign pipe_valid = pipe_wb_en && (pipe_rd != '0);
    assign pipe_grant = pipe_valid && !pipe_stall;
    assign pop        = !pipe_grant && !empty;
    assign lu_ready   = !full;
    assign push       = lu_valid && !full;
    assign push_req   = '{rd: lu_rd, data: lu_data};

    rf_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_req (push_req),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

    always_comb begin
        rf_wb_en   = pipe_grant;
        rf_rd      = pipe_rd;
        rf_wb_data = pipe_wb_data;
        if (pop) begin
            rf_wb_en   = (head.rd != '0);
            rf_rd      = head.rd;
            rf_wb_data = head.data;
        end
    end

    // Set is applied after clear so a same-cycle issue keeps the bit pending.
    always_comb begin
        pending_next = pending;
        if (pop) pending_next[head.rd] = 1'b0;
        if (issue_en) pending_next[issue_rd] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pending <= '0;
        else      pending <= pending_next;
    end

    assign hazard = pending[chk_rs1] | pending[chk_rs2] | pending[chk_rd];
    assign busy   = (|pending) | !empty;

`ifdef RF_ARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             stall_q;
    logic             blocked;

    assign blocked    = !empty && pipe_grant;
    assign pipe_stall = stall_q;

    // Stall is registered off the blocked cycle that brings the count to the
    // limit, so it appears in the cycle right after that many blocked cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
            stall_q    <= 1'b0;
        end else begin
            if (pop || stall_q)  starve_cnt <= '0;
            else if (blocked)    starve_cnt <= starve_cnt + 1'b1;
            stall_q <= blocked && (starve_cnt == CNT_W'(STARVE_LIMIT - 1));
        end
    end
`else
    logic cfg_unused;
    assign cfg_unused = |STARVE_LIMIT;
    assign pipe_stall = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed scoreboard bench for rf_wb_arbiter: expected register-file writes
// are queued by the stimulus and consumed by an independent write monitor.
module tb_rf_wb_arbiter;
    import rf_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_wb_en;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wb_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic [4:0]  chk_rd;
    logic        hazard;
    logic        busy;
    logic        pipe_stall;
    logic        rf_wb_en;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wb_data;

    int      n_cmp = 0;
    int      n_bad = 0;
    wb_req_t exp_q[$];
    wb_req_t mon_e;

    always #5 clk = ~clk;

    rf_wb_arbiter #(
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_wb_en   (pipe_wb_en),
        .pipe_rd      (pipe_rd),
        .pipe_wb_data (pipe_wb_data),
        .lu_valid     (lu_valid),
        .lu_ready     (lu_ready),
        .lu_rd        (lu_rd),
        .lu_data      (lu_data),
        .issue_en     (issue_en),
        .issue_rd     (issue_rd),
        .chk_rs1      (chk_rs1),
        .chk_rs2      (chk_rs2),
        .chk_rd       (chk_rd),
        .hazard       (hazard),
        .busy         (busy),
        .pipe_stall   (pipe_stall),
        .rf_wb_en     (rf_wb_en),
        .rf_rd        (rf_rd),
        .rf_wb_data   (rf_wb_data)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // Monitor: every register-file write must match the oldest expectation.
    always @(negedge clk) begin
        if (rf_wb_en !== 1'b0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got rd=%0d data=0x%0h en=%b, expected no write",
                         rf_rd, rf_wb_data, rf_wb_en);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_rd", 32'(rf_rd), 32'(mon_e.rd));
                chk("wb_data", rf_wb_data, mon_e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
        exp_q.push_back('{rd: rd, data: data});
    endtask

    task automatic pipe_w(input logic [4:0] rd, input logic [31:0] data);
        pipe_wb_en   = 1'b1;
        pipe_rd      = rd;
        pipe_wb_data = data;
        if (rd != 5'd0) expect_wr(rd, data);
    endtask

    task automatic pipe_idle();
        pipe_wb_en   = 1'b0;
        pipe_rd      = 5'd0;
        pipe_wb_data = 32'h0;
    endtask

    initial begin
        rst = 1'b0;
        pipe_idle();
        lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'h0;
        issue_en = 1'b0; issue_rd = 5'd0;
        chk_rs1 = 5'd0; chk_rs2 = 5'd0; chk_rd = 5'd0;

        // Reset state
        step(); step();
        @(negedge clk);
        chk("rst_lu_ready", 32'(lu_ready), 32'd1);
        chk("rst_hazard", 32'(hazard), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pipe_stall", 32'(pipe_stall), 32'd0);
        chk("rst_rf_wb_en_idle", 32'(rf_wb_en), 32'd0);
        step(); pipe_w(5'd5, 32'hDEADBEEF);
        @(negedge clk); chk("rst_rf_wb_en_pipe", 32'(rf_wb_en), 32'd1);

        // Pipe pass-through and x0 drop
        step(); rst = 1'b1; pipe_w(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        chk("pipe_en", 32'(rf_wb_en), 32'd1);
        chk("pipe_rd", 32'(rf_rd), 32'd5);
        step(); pipe_w(5'd0, 32'h0BAD0BAD);
        @(negedge clk); chk("x0_drop", 32'(rf_wb_en), 32'd0);

        // Issue, hazard, long-latency return through idle slot
        step(); pipe_idle(); issue_en = 1'b1; issue_rd = 5'd7;
        step(); issue_en = 1'b0; chk_rs1 = 5'd7;
        @(negedge clk);
        chk("haz_set", 32'(hazard), 32'd1);
        chk("busy_pending", 32'(busy), 32'd1);
        step(); lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h1234;
        @(negedge clk);
        chk("no_bypass", 32'(rf_wb_en), 32'd0);
        chk("haz_during_push", 32'(hazard), 32'd1);
        step(); lu_valid = 1'b0; expect_wr(5'd7, 32'h1234);
        @(negedge clk);
        chk("lu_write_en", 32'(rf_wb_en), 32'd1);
        chk("haz_in_write_cycle", 32'(hazard), 32'd1);
        step();
        @(negedge clk);
        chk("haz_cleared", 32'(hazard), 32'd0);
        chk("busy_cleared", 32'(busy), 32'd0);
        chk_rs1 = 5'd0;

        // Pipe busy every cycle while three results are offered
        step(); pipe_w(5'd1, 32'hA1); lu_valid = 1'b1; lu_rd = 5'd10; lu_data = 32'h100;
        @(negedge clk); chk("ready_0", 32'(lu_ready), 32'd1);
        step(); pipe_w(5'd2, 32'hA2); lu_rd = 5'd11; lu_data = 32'h101;
        @(negedge clk); chk("ready_1", 32'(lu_ready), 32'd1);
        step(); pipe_w(5'd3, 32'hA3); lu_rd = 5'd12; lu_data = 32'h102;
        @(negedge clk); chk("full_2", 32'(lu_ready), 32'd0);
        step(); pipe_w(5'd4, 32'hA4);
        @(negedge clk);
        chk("full_held", 32'(lu_ready), 32'd0);
        chk("busy_fifo", 32'(busy), 32'd1);
        step(); pipe_idle(); expect_wr(5'd10, 32'h100);
        @(negedge clk); chk("full_with_pop", 32'(lu_ready), 32'd0);
        step(); expect_wr(5'd11, 32'h101);
        @(negedge clk); chk("ready_after_pop", 32'(lu_ready), 32'd1);
        step(); lu_valid = 1'b0; expect_wr(5'd12, 32'h102);
        @(negedge clk); chk("busy_last_pop", 32'(busy), 32'd1);
        step();
        @(negedge clk); chk("busy_drained", 32'(busy), 32'd0);

        // Same-cycle set and clear of rd 9: set wins
        step(); issue_en = 1'b1; issue_rd = 5'd9;
        step(); issue_en = 1'b0; lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h99; chk_rs1 = 5'd9;
        step(); lu_valid = 1'b0; issue_en = 1'b1; issue_rd = 5'd9; expect_wr(5'd9, 32'h99);
        step(); issue_en = 1'b0;
        @(negedge clk);
        chk("set_wins_hazard", 32'(hazard), 32'd1);
        chk("set_wins_busy", 32'(busy), 32'd1);

`ifdef RF_ARB_STARVE_GUARD_EN
        // Starvation guard: one buffered entry, pipe writing continuously
        step(); pipe_w(5'd1, 32'hB0); lu_valid = 1'b1; lu_rd = 5'd15; lu_data = 32'h55;
        for (int i = 1; i <= 8; i++) begin
            step(); lu_valid = 1'b0; pipe_w(5'(i + 1), 32'hB000 + 32'(i));
            @(negedge clk); chk("guard_quiet", 32'(pipe_stall), 32'd0);
        end
        step();
        pipe_wb_en = 1'b1; pipe_rd = 5'd20; pipe_wb_data = 32'hC0;
        expect_wr(5'd15, 32'h55);
        @(negedge clk); chk("guard_stall", 32'(pipe_stall), 32'd1);
        step(); pipe_w(5'd20, 32'hC0);
        @(negedge clk); chk("guard_one_cycle", 32'(pipe_stall), 32'd0);
        step(); pipe_idle();
`else
        // Without the guard the pipe is never stalled
        step(); pipe_w(5'd1, 32'hB0); lu_valid = 1'b1; lu_rd = 5'd15; lu_data = 32'h55;
        for (int i = 1; i <= 12; i++) begin
            step(); lu_valid = 1'b0; pipe_w(5'(i + 1), 32'hB000 + 32'(i));
            @(negedge clk); chk("no_guard_stall", 32'(pipe_stall), 32'd0);
        end
        step(); pipe_idle(); expect_wr(5'd15, 32'h55);
        @(negedge clk); chk("no_guard_drain", 32'(rf_wb_en), 32'd1);
`endif

        // Asynchronous reset with buffered entries and pending bits
        step(); issue_en = 1'b1; issue_rd = 5'd13;
        step(); issue_rd = 5'd14;
        step(); issue_en = 1'b0; pipe_w(5'd2, 32'hD0); lu_valid = 1'b1; lu_rd = 5'd20; lu_data = 32'h200;
        step(); pipe_w(5'd3, 32'hD1); lu_rd = 5'd21; lu_data = 32'h201;
        step(); lu_valid = 1'b0; pipe_w(5'd4, 32'hD2); chk_rs1 = 5'd13;
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_hazard", 32'(hazard), 32'd1);
        chk("pre_rst_full", 32'(lu_ready), 32'd0);
        step(); pipe_idle(); rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_hazard", 32'(hazard), 32'd0);
        chk("mid_rst_ready", 32'(lu_ready), 32'd1);
        chk("mid_rst_wb_en", 32'(rf_wb_en), 32'd0);
        step(); rst = 1'b1;
        repeat (4) step();
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_hazard", 32'(hazard), 32'd0);

        step();
        chk("leftover_expected", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
